button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16, meaning consecutive stable cycles required to accept a new button level (legal range 1..65535).
REQ-002 SHALL have parameter REPEAT_CYCLES, default 64, meaning the auto-repeat pulse period in cycles; it is used only when HOLD_REPEAT_EN is defined (legal minimum 2).
REQ-003 SHALL have port clk, input, 1 bit: the clock; all logic is rising-edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port btn1_raw, input, 1 bit: asynchronous, bouncy pushbutton 1 (active-high).
REQ-006 SHALL have port btn2_raw, input, 1 bit: asynchronous, bouncy pushbutton 2 (active-high).
REQ-007 SHALL have port p1, output, 1 bit: one-cycle press pulse for button 1, feeding the downstream sequence detector input P1.
REQ-008 SHALL have port p2, output, 1 bit: one-cycle press pulse for button 2, feeding the downstream sequence detector input P2.
REQ-009 SHALL have port p1_level, output, 1 bit: debounced level of button 1.
REQ-010 SHALL have port p2_level, output, 1 bit: debounced level of button 2.

Function
REQ-011 SHALL implement two identical, fully independent channels (btn1 to p1/p1_level, btn2 to p2/p2_level), each with a private synchronizer, counter and pulse logic.
REQ-012 SHALL pass each raw input through a 2-flop synchronizer (sync1 then sync2) before any other use.
REQ-013 SHALL increment a per-channel debounce counter, of width clog2(DEBOUNCE_CYCLES+1) and minimum 1 bit, on every edge where sync2 differs from the level, and clear it on every edge where they are equal.
REQ-014 SHALL toggle the level and clear the counter on the edge where the counter would reach DEBOUNCE_CYCLES; the counter SHALL never wrap.
REQ-015 SHALL, for a raw input held stable, change the level on the (DEBOUNCE_CYCLES+2)th rising edge after it is first sampled, counting the sampling edge as edge 1.
REQ-016 SHALL leave the level unchanged for any disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sync2 cycles (bounce or glitch rejection).
REQ-017 SHALL drive p1/p2 as registered outputs, high for exactly one cycle starting at the same edge on which the matching level goes from 0 to 1.
REQ-018 SHALL generate no pulse on a level transition from 1 to 0 (release).
REQ-019 SHALL assert both pulses in the same cycle when both channels qualify on the same edge; no arbitration or priority is applied.
REQ-020 SHALL hold a pulse to exactly one cycle regardless of how long the button is held, except as stated in REQ-025.

Reset
REQ-021 SHALL clear the synchronizer flops, counters, levels, p1, p2 and the repeat counters to 0 asynchronously while reset is high.
REQ-022 SHALL abort any debounce or repeat count in progress when reset is asserted mid-operation; on release, a button already held is treated as a new press and pulses after the REQ-015 latency.
REQ-023 SHALL produce no pulse during the reset-release cycle.

Configuration
REQ-024 SHALL compile the auto-repeat feature in only when macro HOLD_REPEAT_EN is defined.
REQ-025 SHALL, with HOLD_REPEAT_EN defined, emit an additional one-cycle pulse every REPEAT_CYCLES cycles after the initial press pulse while the level stays 1, with the repeat counter cleared on release or reset.
REQ-026 SHALL, without HOLD_REPEAT_EN, emit exactly one pulse per press, include no repeat logic, and ignore REPEAT_CYCLES.

Verification (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
REQ-027 SHALL cover a clean press: btn1_raw rises and is sampled at edge 1 -> p1_level and p1 rise at edge 6, p1 falls at edge 7, and p1_level stays 1.
REQ-028 SHALL cover bounce: btn1_raw toggles with 3-cycle high and 1-cycle low glitches for 20 cycles, then stays high -> exactly one p1 pulse, occurring 6 edges after the final stable sample.
REQ-029 SHALL cover simultaneous press: btn1_raw and btn2_raw rise on the same edge -> p1 and p2 are both high in the same single cycle.
REQ-030 SHALL cover release: button held for 50 cycles, then released -> p1_level falls 6 edges after release, and no pulse occurs on release (count of 1 pulse without HOLD_REPEAT_EN).
REQ-031 SHALL cover reset mid-debounce: reset asserted 2 cycles into the count with the button still held -> all outputs are 0 immediately, and p1 fires 6 edges after reset release.
REQ-032 SHALL cover repeat with HOLD_REPEAT_EN: button held for 30 cycles after the initial pulse -> additional pulses at +8, +16 and +24 cycles after it.

Source files
------------

// File: rtl/button_conditioner.sv
// Two-channel pushbutton conditioner: 2-flop synchronizer, debounce counter and
// registered press pulse per button; channels are fully independent.
// Optional auto-repeat while held is compiled in with `define HOLD_REPEAT_EN.

// One button channel: synchronize, debounce into a level, pulse on press.
// Latency: a stable raw level is reflected on the (DEBOUNCE_CYCLES+2)th edge.
// No backpressure: pulses are single-cycle and cannot be stalled.
module button_channel #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic pulse,
  output logic level
);

  localparam int CW = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Reject illegal parameterisations at elaboration.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_channel: DEBOUNCE_CYCLES must be 1..65535 and REPEAT_CYCLES >= 2");
  end

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          level_nxt;
  logic          press;
  logic          pulse_nxt;

  // Two-flop synchronizer; nothing downstream looks at raw directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count consecutive disagreeing cycles; flip the level instead of reaching DEBOUNCE_CYCLES.
  always_comb begin
    cnt_nxt   = '0;
    level_nxt = level;
    if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        level_nxt = ~level;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  assign press = ~level & level_nxt;

`ifdef HOLD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;
  logic [RW-1:0] rep_nxt;
  logic          rep_fire;

  // While held, count cycles since the last pulse and fire every REPEAT_CYCLES.
  always_comb begin
    rep_nxt  = '0;
    rep_fire = 1'b0;
    if (level && level_nxt) begin
      if (rep_cnt == REP_LAST) begin
        rep_fire = 1'b1;
      end else begin
        rep_nxt = rep_cnt + 1'b1;
      end
    end
  end

  // Repeat counter register; cleared by release (level low) and by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_nxt;
    end
  end

  assign pulse_nxt = press | rep_fire;
`else
  assign pulse_nxt = press;
`endif

  // Debounce state and the registered pulse, which rises with the level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
      pulse <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      level <= level_nxt;
      pulse <= pulse_nxt;
    end
  end

endmodule

// Top: two independent channels feeding the sequence detector inputs P1/P2.
// Latency: DEBOUNCE_CYCLES+2 edges from first sample of a stable level.
// No backpressure; simultaneous presses pulse together with no priority.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic btn1_raw,
  input  logic btn2_raw,
  output logic p1,
  output logic p2,
  output logic p1_level,
  output logic p2_level
);

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_ch1 (
    .clk   (clk),
    .reset (reset),
    .raw   (btn1_raw),
    .pulse (p1),
    .level (p1_level)
  );

  button_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
  ) u_ch2 (
    .clk   (clk),
    .reset (reset),
    .raw   (btn2_raw),
    .pulse (p2),
    .level (p2_level)
  );

endmodule
